// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache.
//   state_t        : controller states
//   LINE_W etc.    : fixed geometry of the 128-bit memory bus and line address
//   clog2          : elaboration-time log2 for deriving field widths
//   line_word      : picks 32-bit word k out of a 128-bit line
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MISS  = 2'd1,
    FILL  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam int LINE_W         = 128;
  localparam int WORDS_PER_LINE = 4;
  localparam int MEM_ADDR_W     = 28;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line,
                                            input logic [1:0]        k);
    return line[{k, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/icache_lru.sv
// True-LRU helper for one cache set.
//   age       : per-way age, 0 = most recently used, WAYS-1 = least
//   valid     : per-way valid bits
//   touch_way : way being hit or filled this cycle
//   victim    : lowest-index invalid way, else the way with the oldest age
//   age_next  : age vector after touching touch_way
module icache_lru
  import icache_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int AGE_W = 1
) (
  input  logic [WAYS-1:0][AGE_W-1:0] age,
  input  logic [WAYS-1:0]            valid,
  input  logic [AGE_W-1:0]           touch_way,
  output logic [AGE_W-1:0]           victim,
  output logic [WAYS-1:0][AGE_W-1:0] age_next
);

  logic found_invalid;

  always_comb begin
    victim        = '0;
    found_invalid = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid[w] && !found_invalid) begin
        victim        = AGE_W'(w);
        found_invalid = 1'b1;
      end
    end
    if (!found_invalid) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age[w] == AGE_W'(WAYS - 1)) victim = AGE_W'(w);
      end
    end
  end

  // Everything younger than the touched way ages by one; the touched way
  // becomes youngest. Ages stay a permutation of 0..WAYS-1.
  always_comb begin
    age_next = age;
    for (int w = 0; w < WAYS; w++) begin
      if (age[w] < age[touch_way]) age_next[w] = age[w] + AGE_W'(1);
    end
    age_next[touch_way] = '0;
  end

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative read-only instruction cache.
//   clk, proc_reset_n        : clock, async active-low reset
//   proc_read/addr           : fetch request (word address), held while stalled
//   proc_flush               : one-cycle invalidate-all pulse
//   proc_write/wdata         : ignored
//   proc_stall/rdata         : stall and fetched word
//   mem_read/addr            : line read request to the 128-bit bus
//   mem_rdata/ready          : line data, valid when mem_ready = 1
//   mem_write/wdata          : tied to 0
// Handshakes: a fetch completes in the cycle where proc_read = 1 and
// proc_stall = 0; the core keeps proc_read/proc_addr stable until then.
// A line request is open while mem_read = 1 with mem_addr stable; it
// completes in the cycle mem_ready = 1, and may be abandoned by reset.
module icache_assoc
  import icache_pkg::*;
#(
  parameter int SETS = 4,
  parameter int WAYS = 2
) (
  input  logic                  clk,
  input  logic                  proc_reset_n,
  input  logic                  proc_read,
  input  logic                  proc_write,
  input  logic                  proc_flush,
  input  logic [29:0]           proc_addr,
  input  logic [31:0]           proc_wdata,
  output logic                  proc_stall,
  output logic [31:0]           proc_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0]     mem_wdata,
  input  logic [LINE_W-1:0]     mem_rdata,
  input  logic                  mem_ready
);

  localparam int IDX_W = clog2(SETS);
  localparam int TAG_W = MEM_ADDR_W - IDX_W;
  localparam int AGE_W = clog2(WAYS);

  state_t                   state;
  logic                     flush_pend;
  logic [IDX_W-1:0]         flush_idx;
  logic [MEM_ADDR_W-1:0]    addr_q;
  logic [LINE_W-1:0]        line_buf;
  logic [31:0]              rdata_q;

  logic [WAYS-1:0]            valid_q [SETS];
  logic [WAYS-1:0][AGE_W-1:0] age_q   [SETS];
  logic [TAG_W-1:0]           tag_q   [SETS][WAYS];
  logic [LINE_W-1:0]          line_q  [SETS][WAYS];

  logic [IDX_W-1:0] req_idx, fill_idx, set_idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit;
  logic [AGE_W-1:0] hit_way, victim, touch_way;
  logic [WAYS-1:0][AGE_W-1:0] age_next;
  logic [31:0]      hit_word, fill_word;
  logic             unused_inputs;

  assign req_idx   = proc_addr[1+IDX_W:2];
  assign req_tag   = proc_addr[29:2+IDX_W];
  assign fill_idx  = addr_q[IDX_W-1:0];
  // IDLE works on the live request's set; MISS/FILL on the latched one.
  assign set_idx   = (state == IDLE) ? req_idx : fill_idx;
  assign touch_way = (state == FILL) ? victim : hit_way;
  assign mem_write = 1'b0;
  assign mem_wdata = '0;
  assign unused_inputs = ^{proc_write, proc_wdata};

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
  end

  assign hit_word  = line_word(line_q[req_idx][hit_way], proc_addr[1:0]);
  assign fill_word = line_word(line_buf, proc_addr[1:0]);

  icache_lru #(.WAYS(WAYS), .AGE_W(AGE_W)) u_lru (
    .age       (age_q[set_idx]),
    .valid     (valid_q[set_idx]),
    .touch_way (touch_way),
    .victim    (victim),
    .age_next  (age_next)
  );

  always_comb begin
    proc_stall = 1'b0;
    mem_read   = 1'b0;
    mem_addr   = addr_q;
    proc_rdata = rdata_q;
    case (state)
      IDLE: begin
        if (proc_flush) begin
          proc_stall = 1'b1;
        end else if (proc_read) begin
          if (hit) begin
            proc_rdata = hit_word;
          end else begin
            proc_stall = 1'b1;
            mem_read   = 1'b1;
            mem_addr   = proc_addr[29:2];
          end
        end
      end
      MISS: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
      end
      FILL:    proc_rdata = fill_word;
      FLUSH:   proc_stall = 1'b1;
      default: proc_stall = 1'b0;
    endcase
    // Combinational request paths must not leak out while reset is held.
    if (!proc_reset_n) begin
      proc_stall = 1'b0;
      mem_read   = 1'b0;
      mem_addr   = '0;
      proc_rdata = '0;
    end
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state      <= IDLE;
      flush_pend <= 1'b0;
      flush_idx  <= '0;
      addr_q     <= '0;
      line_buf   <= '0;
      rdata_q    <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w]  <= AGE_W'(w);
          tag_q[s][w]  <= '0;
          line_q[s][w] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (proc_flush) begin
            state <= FLUSH;
          end else if (proc_read) begin
            if (hit) begin
              rdata_q        <= hit_word;
              age_q[req_idx] <= age_next;
            end else begin
              addr_q <= proc_addr[29:2];
              state  <= MISS;
            end
          end
        end
        MISS: begin
          if (proc_flush) flush_pend <= 1'b1;
          if (mem_ready) begin
            line_buf <= mem_rdata;
            state    <= FILL;
          end
        end
        FILL: begin
          valid_q[fill_idx][victim] <= 1'b1;
          tag_q[fill_idx][victim]   <= addr_q[MEM_ADDR_W-1:IDX_W];
          line_q[fill_idx][victim]  <= line_buf;
          age_q[fill_idx]           <= age_next;
          rdata_q                   <= fill_word;
          state <= (flush_pend || proc_flush) ? FLUSH : IDLE;
        end
        FLUSH: begin
          valid_q[flush_idx] <= '0;
          for (int w = 0; w < WAYS; w++) age_q[flush_idx][w] <= AGE_W'(w);
          if (flush_idx == IDX_W'(SETS - 1)) begin
            flush_idx  <= '0;
            flush_pend <= 1'b0;
            state      <= IDLE;
          end else begin
            flush_idx <= flush_idx + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc (SETS=4, WAYS=4). The reference model keeps, per
// set, the resident lines in most-recently-used-first order; a miss on a
// full set evicts the last entry.
module tb_icache_assoc;

  localparam int SETS = 4;
  localparam int WAYS = 4;

  logic         clk = 1'b0;
  logic         proc_reset_n = 1'b1;
  logic         proc_read = 1'b0;
  logic         proc_write = 1'b0;
  logic         proc_flush = 1'b0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] last_word = '0;
  logic [31:0] exp_q[$];

  logic [25:0]  m_tag  [SETS][WAYS];
  logic [127:0] m_line [SETS][WAYS];
  int           m_cnt  [SETS];

  icache_assoc #(.SETS(SETS), .WAYS(WAYS)) dut (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .proc_read    (proc_read),
    .proc_write   (proc_write),
    .proc_flush   (proc_flush),
    .proc_addr    (proc_addr),
    .proc_wdata   (proc_wdata),
    .proc_stall   (proc_stall),
    .proc_rdata   (proc_rdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [29:0] mk_addr(input logic [25:0] tg, input int idx, input int w);
    return {tg, 2'(idx), 2'(w)};
  endfunction

  function automatic logic [127:0] mem_line(input logic [27:0] la);
    return {4'd4, la, 4'd3, la, 4'd2, la, 4'd1, la};
  endfunction

  function automatic int model_find(input int idx, input logic [25:0] tg);
    for (int p = 0; p < m_cnt[idx]; p++) begin
      if (m_tag[idx][p] == tg) return p;
    end
    return -1;
  endfunction

  task automatic model_touch(input int idx, input int pos);
    logic [25:0]  t;
    logic [127:0] l;
    t = m_tag[idx][pos];
    l = m_line[idx][pos];
    for (int p = pos; p > 0; p--) begin
      m_tag[idx][p]  = m_tag[idx][p-1];
      m_line[idx][p] = m_line[idx][p-1];
    end
    m_tag[idx][0]  = t;
    m_line[idx][0] = l;
  endtask

  task automatic model_insert(input int idx, input logic [25:0] tg, input logic [127:0] line);
    if (m_cnt[idx] < WAYS) m_cnt[idx]++;
    for (int p = m_cnt[idx] - 1; p > 0; p--) begin
      m_tag[idx][p]  = m_tag[idx][p-1];
      m_line[idx][p] = m_line[idx][p-1];
    end
    m_tag[idx][0]  = tg;
    m_line[idx][0] = line;
  endtask

  task automatic model_flush();
    for (int s = 0; s < SETS; s++) m_cnt[s] = 0;
  endtask

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic fetch(input logic [29:0] a, input int lat, input logic [127:0] line);
    int          idx, pos;
    logic [25:0] tg;
    logic [31:0] exp_word;
    idx = int'(a[3:2]);
    tg  = a[29:4];
    pos = model_find(idx, tg);
    proc_read = 1'b1;
    proc_addr = a;
    @(negedge clk);
    if (pos >= 0) begin
      exp_q.push_back(m_line[idx][pos][32*int'(a[1:0]) +: 32]);
      exp_word = exp_q.pop_front();
      n_tests++;
      if (proc_stall !== 1'b0 || mem_read !== 1'b0) begin
        n_fail++;
        $display("FAIL hit_stall addr=%h got stall=%b mem_read=%b want 0 0", a, proc_stall, mem_read);
      end
      n_tests++;
      if (proc_rdata !== exp_word) begin
        n_fail++;
        $display("FAIL hit_data addr=%h got %h want %h", a, proc_rdata, exp_word);
      end
      model_touch(idx, pos);
      last_word = exp_word;
    end else begin
      n_tests++;
      if (proc_stall !== 1'b1 || mem_read !== 1'b1 || mem_addr !== a[29:2] || mem_write !== 1'b0) begin
        n_fail++;
        $display("FAIL miss_req addr=%h got stall=%b mem_read=%b mem_addr=%h mem_write=%b want 1 1 %h 0",
                 a, proc_stall, mem_read, mem_addr, mem_write, a[29:2]);
      end
      for (int i = 1; i <= lat; i++) begin
        @(posedge clk); #1;
        if (i == lat) begin
          mem_ready = 1'b1;
          mem_rdata = line;
        end else begin
          mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        @(negedge clk);
        n_tests++;
        if (proc_stall !== 1'b1 || mem_read !== 1'b1 || mem_addr !== a[29:2]) begin
          n_fail++;
          $display("FAIL miss_wait addr=%h cyc=%0d got stall=%b mem_read=%b mem_addr=%h want 1 1 %h",
                   a, i, proc_stall, mem_read, mem_addr, a[29:2]);
        end
      end
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
      exp_q.push_back(line[32*int'(a[1:0]) +: 32]);
      exp_word = exp_q.pop_front();
      n_tests++;
      if (proc_stall !== 1'b0 || mem_read !== 1'b0 || proc_rdata !== exp_word) begin
        n_fail++;
        $display("FAIL fill addr=%h got stall=%b mem_read=%b rdata=%h want 0 0 %h",
                 a, proc_stall, mem_read, proc_rdata, exp_word);
      end
      model_insert(idx, tg, line);
      last_word = exp_word;
    end
    @(posedge clk); #1;
    proc_read = 1'b0;
  endtask

  task automatic fetch_mem(input logic [29:0] a, input int lat);
    fetch(a, lat, mem_line(a[29:2]));
  endtask

  // Flush pulse from IDLE; any read already driven is held through it.
  task automatic flush_idle();
    proc_flush = 1'b1;
    @(negedge clk);
    n_tests++;
    if (proc_stall !== 1'b1 || mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_start got stall=%b mem_read=%b want 1 0", proc_stall, mem_read);
    end
    @(posedge clk); #1;
    proc_flush = 1'b0;
    for (int i = 0; i < SETS; i++) begin
      @(negedge clk);
      n_tests++;
      if (proc_stall !== 1'b1 || mem_read !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_busy cyc=%0d got stall=%b mem_read=%b want 1 0", i, proc_stall, mem_read);
      end
      @(posedge clk); #1;
    end
    model_flush();
  endtask

  task automatic idle_cycle();
    proc_read = 1'b0;
    @(negedge clk);
    n_tests++;
    if (proc_stall !== 1'b0 || mem_read !== 1'b0 || proc_rdata !== last_word) begin
      n_fail++;
      $display("FAIL idle_hold got stall=%b mem_read=%b rdata=%h want 0 0 %h",
               proc_stall, mem_read, proc_rdata, last_word);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1 proc_reset_n = 1'b0;
    proc_read = 1'b1;
    proc_addr = 30'h10;
    #2;
    n_tests++;
    if (proc_stall !== 1'b0 || mem_read !== 1'b0 || mem_addr !== 28'h0 || proc_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got stall=%b mem_read=%b mem_addr=%h rdata=%h want 0 0 0 0",
               proc_stall, mem_read, mem_addr, proc_rdata);
    end
    n_tests++;
    if (mem_write !== 1'b0 || mem_wdata !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_tied got mem_write=%b mem_wdata=%h want 0 0", mem_write, mem_wdata);
    end
    proc_read = 1'b0;
    model_flush();
    last_word = '0;
    repeat (2) @(posedge clk);
    #1 proc_reset_n = 1'b1;
  endtask

  task automatic test_cold_miss();
    logic [127:0] pat;
    pat = 128'h44444444_33333333_22222222_11111111;
    fetch(30'h0000010, 3, pat);
    fetch(30'h0000011, 1, pat);
    idle_cycle();
  endtask

  task automatic test_lru();
    logic [25:0] tg_a, tg_b, tg_c, tg_d, tg_e;
    tg_a = 26'h100; tg_b = 26'h101; tg_c = 26'h102; tg_d = 26'h103; tg_e = 26'h104;
    fetch_mem(mk_addr(tg_a, 0, 0), 1);
    fetch_mem(mk_addr(tg_b, 0, 1), 2);
    fetch_mem(mk_addr(tg_c, 0, 2), 1);
    fetch_mem(mk_addr(tg_d, 0, 3), 3);
    fetch_mem(mk_addr(tg_a, 0, 2), 1);
    fetch_mem(mk_addr(tg_e, 0, 0), 2);
    fetch_mem(mk_addr(tg_a, 0, 1), 1);
    fetch_mem(mk_addr(tg_c, 0, 3), 1);
    fetch_mem(mk_addr(tg_d, 0, 0), 1);
    fetch_mem(mk_addr(tg_b, 0, 1), 1);
  endtask

  task automatic test_flush_during_miss();
    logic [29:0]  a;
    logic [127:0] line;
    logic [31:0]  exp_word;
    a    = mk_addr(26'h155, 2, 1);
    line = mem_line(a[29:2]);
    proc_read = 1'b1;
    proc_addr = a;
    @(negedge clk);
    n_tests++;
    if (mem_read !== 1'b1 || proc_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL fdm_req got mem_read=%b stall=%b want 1 1", mem_read, proc_stall);
    end
    @(posedge clk); #1;
    proc_flush = 1'b1;
    @(negedge clk);
    n_tests++;
    if (mem_read !== 1'b1 || proc_stall !== 1'b1 || mem_addr !== a[29:2]) begin
      n_fail++;
      $display("FAIL fdm_wait got mem_read=%b stall=%b mem_addr=%h want 1 1 %h",
               mem_read, proc_stall, mem_addr, a[29:2]);
    end
    @(posedge clk); #1;
    proc_flush = 1'b0;
    mem_ready  = 1'b1;
    mem_rdata  = line;
    @(negedge clk);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    exp_word = line[32 +: 32];
    n_tests++;
    if (proc_stall !== 1'b0 || mem_read !== 1'b0 || proc_rdata !== exp_word) begin
      n_fail++;
      $display("FAIL fdm_fill got stall=%b mem_read=%b rdata=%h want 0 0 %h",
               proc_stall, mem_read, proc_rdata, exp_word);
    end
    last_word = exp_word;
    @(posedge clk); #1;
    proc_read = 1'b0;
    for (int i = 0; i < SETS; i++) begin
      @(negedge clk);
      n_tests++;
      if (proc_stall !== 1'b1) begin
        n_fail++;
        $display("FAIL fdm_flush cyc=%0d got stall=%b want 1", i, proc_stall);
      end
      @(posedge clk); #1;
    end
    model_flush();
    fetch_mem(a, 2);
  endtask

  task automatic test_flush_and_read();
    logic [29:0] a;
    a = mk_addr(26'h155, 2, 3);
    fetch_mem(a, 1);
    proc_read = 1'b1;
    proc_addr = a;
    flush_idle();
    fetch_mem(a, 2);
  endtask

  task automatic test_reset_mid_miss();
    logic [29:0] a;
    a = mk_addr(26'h3FF, 1, 2);
    fetch_mem(a, 1);
    proc_read = 1'b1;
    proc_addr = mk_addr(26'h3FE, 1, 0);
    @(posedge clk); #1;
    proc_reset_n = 1'b0;
    #1;
    n_tests++;
    if (mem_read !== 1'b0 || proc_stall !== 1'b0 || mem_addr !== 28'h0 || proc_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_miss got mem_read=%b stall=%b mem_addr=%h rdata=%h want 0 0 0 0",
               mem_read, proc_stall, mem_addr, proc_rdata);
    end
    proc_read = 1'b0;
    @(negedge clk);
    proc_reset_n = 1'b1;
    model_flush();
    last_word = '0;
    @(posedge clk); #1;
    idle_cycle();
    fetch_mem(a, 1);
  endtask

  task automatic test_write_ignored();
    logic [29:0] a;
    a = mk_addr(26'h0AA, 3, 2);
    fetch_mem(a, 1);
    proc_write = 1'b1;
    proc_wdata = $urandom();
    proc_addr  = a;
    proc_read  = 1'b0;
    @(negedge clk);
    n_tests++;
    if (proc_stall !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 || proc_rdata !== last_word) begin
      n_fail++;
      $display("FAIL write_only got stall=%b mem_read=%b mem_write=%b rdata=%h want 0 0 0 %h",
               proc_stall, mem_read, mem_write, proc_rdata, last_word);
    end
    @(posedge clk); #1;
    fetch_mem(a, 1);
    fetch_mem(mk_addr(26'h0AA, 3, 0), 1);
    proc_write = 1'b0;
  endtask

  task automatic test_random();
    int          r;
    logic [29:0] a;
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 19);
      proc_write = 1'($urandom_range(0, 1));
      proc_wdata = $urandom();
      if (r == 0) begin
        flush_idle();
      end else if (r == 1) begin
        idle_cycle();
      end else begin
        a = mk_addr(26'h200 + 26'($urandom_range(0, 5)), $urandom_range(0, SETS - 1),
                    $urandom_range(0, 3));
        fetch_mem(a, $urandom_range(1, 4));
      end
    end
    proc_write = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_cold_miss();
    test_lru();
    test_flush_during_miss();
    test_flush_and_read();
    test_reset_mid_miss();
    test_write_ignored();
    test_random();
    idle_cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
